lut_frame_decoder: RTL and testbench
====================================

Name: lut_frame_decoder

Overview:
Inverse of the XYBel-to-frame-address translator. Takes a configuration frame address, a word offset, and LUT/half select bits. Returns the packed CLB location XYBel = {X[14:0], Y[14:0], Bel[1:0]}. It sits on the readback/verification path so that captured frame words can be attributed to a LUT site.

Parameters:
Max_Y, 150, number of CLB rows; Y results >= Max_Y are errors
Y_Half, 50, row count of the top half
Coloumn_HT, 50, rows per HCLK region
Col_Half, 25, row split inside one region for word-offset banding
Max_HCLK, 1, highest legal HCLK value when Top=0

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request pulse; sampled only in IDLE
Frame_address  input  32  {6'd0, Block_Type[2:0], Top, HCLK[4:0], Major[9:0], Minor[6:0]}
word_offset  input  8  frame word index
Lut_hi  input  1  Bel[1]: 0 = LUTA/B, 1 = LUTC/D
msb_lsb  input  1  Bel[0]
Row_odd  input  1  LSB of the in-region row; word offset does not encode it
XYBel  output  32  {X[14:0], Y[14:0], Bel[1:0]}
busy  output  1  high from accepted Start until done_XY
done_XY  output  1  one-cycle pulse; results valid
error  output  1  held with done_XY data until next Start
err_code  output  3  0 ok, 1 bad Minor, 2 bad Major, 3 bad word_offset/Row_odd, 4 bad Block_Type/upper bits/Top/HCLK/Y range

Behaviour:
- Reset (async, Reset_n=0): state IDLE; XYBel=0, busy=0, done_XY=0, error=0, err_code=0; all latched inputs cleared. Reset mid-operation aborts, and no done_XY is produced.
- FSM: IDLE -> LATCH -> COLUMN -> ROW -> DONE -> IDLE. Each state lasts one cycle.
- IDLE: Start=1 registers all inputs, sets busy=1, and clears error/err_code.
- Start while busy is ignored. No queueing.
- LATCH: splits the frame address into fields.
  - Code 4 if FA[31:23] != 0.
  - Code 4 if Top=0 and HCLK > Max_HCLK.
- COLUMN:
  - Minor=32 gives X[0]=0. Minor=26 gives X[0]=1. Any other Minor gives code 1.
  - Major ranges and k: 2..5 k=2; 7..16 k=3; 18..19 k=4; 21..28 k=5; 30..41 k=6; 43..52 k=7; 54..57 k=8; 59..62 k=9.
  - X = ((Major-k)<<1) | X[0].
  - Any other Major (including the gaps 6, 17, 20, 29, 42, 53, 58) gives code 2.
- ROW (Yo = in-region row, r = Row_odd):
  - Lut_hi=0, wo 1..13: Yo = 2*(wo-1)+r; wo=13 requires r=0.
  - Lut_hi=0, wo 14..26: Yo = 2*(wo-2)+r; wo=14 requires r=1.
  - Lut_hi=1, wo 2..14: Yo = 2*(wo-2)+r; wo=14 requires r=0.
  - Lut_hi=1, wo 15..27: Yo = 2*(wo-3)+r; wo=15 requires r=1.
  - Any other wo/r combination gives code 3.
  - Top=1: Y = Yo. Top=0: Y = Y_Half + HCLK*Coloumn_HT + Yo.
  - Y is computed in 15 bits. Y >= Max_Y gives code 4.
- DONE:
  - XYBel = {X, Y, Lut_hi, msb_lsb} if no error. XYBel = 0 if error.
  - done_XY=1 for this cycle only. busy drops the same cycle. Outputs hold until the next accepted Start.
- Error priority: the lowest non-zero code detected wins.
- Latency: done_XY is asserted 4 cycles after the Start sampling edge. Back-to-back Start is accepted on the cycle after DONE.

Decomposition:
- Shared package holds:
  - state encoding (IDLE..DONE);
  - err_code constants;
  - frame-address field positions (Block_Type 25:23, Top 22, HCLK 21:17, Major 16:7, Minor 6:0);
  - Minor constants 32/26;
  - the Major range/offset table, shared with the forward translator.
- One natural sub-module: major_to_x, a combinational Major -> {X[14:1], valid} range decoder. The FSM, row arithmetic and output registers stay in the top level.

Test Plan:
- FA Top=0, HCLK=0, Major=2, Minor=32; wo=1, Lut_hi=0, r=0, msb_lsb=0 -> XYBel=0x000000C8 (X=0, Y=50, Bel=0), error=0, done_XY 4 cycles after Start.
- FA Top=1, Major=19, Minor=26; wo=15, Lut_hi=1, r=1, msb_lsb=1 -> X=31, Y=25, Bel=3, XYBel=0x003E0067.
- FA Top=0, HCLK=1, Major=62, Minor=26; wo=26, Lut_hi=0, r=1 -> X=107, Y=149, XYBel=0x00D60254 (Bel=0 for msb_lsb=0).
- Major=6 (gap) with valid Minor -> error=1, err_code=2, XYBel=0. Minor=5 with Major=6 -> err_code=1 (priority).
- wo=13, Lut_hi=0, r=1 -> err_code=3. Top=0 with HCLK=2 -> err_code=4. Block_Type=1 -> err_code=4.
- Start held high for 10 cycles -> exactly two done_XY pulses, 5 cycles apart.
- Reset_n low during ROW -> outputs go to 0 immediately and no done_XY follows.
- After Reset_n deasserts, a new Start completes normally.

Source files
------------

// File: rtl/lut_frame_decoder_pkg.sv
// Shared definitions for the LUT frame-address decoder: FSM encoding,
// error codes, frame-address field layout, and the Major -> column table.
package lut_frame_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_COLUMN = 3'd2,
        ST_ROW    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_OK     = 3'd0;
    localparam logic [2:0] ERR_MINOR  = 3'd1;
    localparam logic [2:0] ERR_MAJOR  = 3'd2;
    localparam logic [2:0] ERR_OFFSET = 3'd3;
    localparam logic [2:0] ERR_RANGE  = 3'd4;

    // Frame address layout: {6'd0, Block_Type, Top, HCLK, Major, Minor}
    localparam int FA_UPPER_MSB = 31;
    localparam int FA_UPPER_LSB = 23;
    localparam int FA_TOP       = 22;
    localparam int FA_HCLK_MSB  = 21;
    localparam int FA_HCLK_LSB  = 17;
    localparam int FA_MAJOR_MSB = 16;
    localparam int FA_MAJOR_LSB = 7;
    localparam int FA_MINOR_MSB = 6;
    localparam int FA_MINOR_LSB = 0;

    // Minor frame selecting the even (X0) or odd (X1) column of a CLB pair
    localparam logic [6:0] MINOR_X0 = 7'd32;
    localparam logic [6:0] MINOR_X1 = 7'd26;

    // Device geometry
    localparam logic [14:0] MAX_Y    = 15'd150;
    localparam logic [14:0] Y_HALF   = 15'd50;
    localparam logic [14:0] COL_HT   = 15'd50;
    localparam logic [7:0]  COL_HALF = 8'd25;
    localparam logic [4:0]  MAX_HCLK = 5'd1;

    // Word-offset bands (after removing the Lut_hi shift): band 0 covers the
    // lower COL_HALF rows of a region, band 1 the upper ones.
    localparam logic [7:0] WO_B0_LO = 8'd1;
    localparam logic [7:0] WO_B0_HI = 8'((COL_HALF + 8'd1) >> 1);
    localparam logic [7:0] WO_B1_LO = 8'(WO_B0_HI + 8'd1);
    localparam logic [7:0] WO_B1_HI = 8'(COL_HALF + 8'd1);

    // Major range table: Majors lo..hi map to column pair (Major - k)
    localparam int MAJOR_RANGES = 8;
    localparam logic [9:0] MAJOR_LO [MAJOR_RANGES] = '{10'd2,  10'd7,  10'd18, 10'd21,
                                                       10'd30, 10'd43, 10'd54, 10'd59};
    localparam logic [9:0] MAJOR_HI [MAJOR_RANGES] = '{10'd5,  10'd16, 10'd19, 10'd28,
                                                       10'd41, 10'd52, 10'd57, 10'd62};
    localparam logic [9:0] MAJOR_K  [MAJOR_RANGES] = '{10'd2,  10'd3,  10'd4,  10'd5,
                                                       10'd6,  10'd7,  10'd8,  10'd9};

    // Combine a newly detected code with the accumulated one; lowest non-zero wins
    function automatic logic [2:0] merge_err(input logic [2:0] cur, input logic [2:0] new_code);
        logic [2:0] res;
        if (new_code == ERR_OK) begin
            res = cur;
        end else if ((cur == ERR_OK) || (new_code < cur)) begin
            res = new_code;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/lut_frame_decoder_if.sv
// Request/response bundle between a readback controller and the decoder.
interface lut_frame_decoder_if;
    logic        Start;
    logic [31:0] Frame_address;
    logic [7:0]  word_offset;
    logic        Lut_hi;
    logic        msb_lsb;
    logic        Row_odd;
    logic [31:0] XYBel;
    logic        busy;
    logic        done_XY;
    logic        error;
    logic [2:0]  err_code;

    modport master (
        output Start, Frame_address, word_offset, Lut_hi, msb_lsb, Row_odd,
        input  XYBel, busy, done_XY, error, err_code
    );

    modport slave (
        input  Start, Frame_address, word_offset, Lut_hi, msb_lsb, Row_odd,
        output XYBel, busy, done_XY, error, err_code
    );
endinterface

// File: rtl/lut_frame_decoder_major_to_x.sv
// Combinational Major -> column-pair decoder; o_valid is low for Majors
// that fall outside every CLB range (including the non-CLB gap columns).
module lut_frame_decoder_major_to_x
    import lut_frame_decoder_pkg::*;
(
    input  logic [9:0]  i_major,
    output logic [13:0] o_x_hi,
    output logic        o_valid
);

    // Search the range table; ranges are disjoint so at most one hits
    always_comb begin
        o_x_hi  = 14'd0;
        o_valid = 1'b0;
        for (int i = 0; i < MAJOR_RANGES; i++) begin
            if ((i_major >= MAJOR_LO[i]) && (i_major <= MAJOR_HI[i])) begin
                o_x_hi  = 14'(i_major - MAJOR_K[i]);
                o_valid = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/lut_frame_decoder.sv
// Frame address + word offset -> XYBel decoder. A four-stage walk
// (LATCH, COLUMN, ROW, DONE) with errors accumulated across stages.
module lut_frame_decoder (
    input  logic                 Clk,
    input  logic                 Reset_n,
    lut_frame_decoder_if.slave   bus
);
    import lut_frame_decoder_pkg::*;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;

    logic [31:0] r_fa;
    logic [7:0]  r_wo;
    logic        r_lh;
    logic        r_ml;
    logic        r_ro;

    logic        r_top;
    logic [4:0]  r_hclk;
    logic [9:0]  r_major;
    logic [6:0]  r_minor;

    logic [14:0] r_x;
    logic [14:0] r_y;
    logic [2:0]  r_err;

    logic [31:0] r_xybel;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [2:0]  r_err_code;

    logic [2:0]  w_latch_code;
    logic [13:0] w_x_hi;
    logic        w_major_ok;
    logic        w_x0;
    logic [2:0]  w_col_code;
    logic [7:0]  w_base;
    logic [14:0] w_yo;
    logic        w_row_ok;
    logic [14:0] w_y;
    logic [2:0]  w_row_code;

    assign w_accept = (r_state == ST_IDLE) && bus.Start;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: one cycle per stage, Start only considered when idle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   w_next_state = bus.Start ? ST_LATCH : ST_IDLE;
            ST_LATCH:  w_next_state = ST_COLUMN;
            ST_COLUMN: w_next_state = ST_ROW;
            ST_ROW:    w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Upper bits / Block_Type must be zero; bottom half only has HCLK 0..MAX_HCLK
    always_comb begin
        if ((r_fa[FA_UPPER_MSB:FA_UPPER_LSB] != 9'd0) ||
            (!r_fa[FA_TOP] && (r_fa[FA_HCLK_MSB:FA_HCLK_LSB] > MAX_HCLK))) begin
            w_latch_code = ERR_RANGE;
        end else begin
            w_latch_code = ERR_OK;
        end
    end

    lut_frame_decoder_major_to_x u_major_to_x (
        .i_major (r_major),
        .o_x_hi  (w_x_hi),
        .o_valid (w_major_ok)
    );

    assign w_x0 = (r_minor == MINOR_X1);

    // Minor selects the column within the pair; Major selects the pair
    always_comb begin
        if ((r_minor != MINOR_X0) && (r_minor != MINOR_X1)) begin
            w_col_code = ERR_MINOR;
        end else if (!w_major_ok) begin
            w_col_code = ERR_MAJOR;
        end else begin
            w_col_code = ERR_OK;
        end
    end

    // Lut_hi shifts the word-offset bands up by one word
    assign w_base = r_wo - {7'd0, r_lh};

    // Word offset gives row pairs; the band edges each carry only one parity
    always_comb begin
        w_yo     = 15'd0;
        w_row_ok = 1'b0;
        if ((w_base >= WO_B0_LO) && (w_base <= WO_B0_HI)) begin
            w_yo     = 15'({w_base - 8'd1, r_ro});
            w_row_ok = !((w_base == WO_B0_HI) && r_ro);
        end else if ((w_base >= WO_B1_LO) && (w_base <= WO_B1_HI)) begin
            w_yo     = 15'({w_base - 8'd2, r_ro});
            w_row_ok = !((w_base == WO_B1_LO) && !r_ro);
        end else begin
            w_yo     = 15'd0;
            w_row_ok = 1'b0;
        end
    end

    assign w_y = r_top ? w_yo : (Y_HALF + (15'(r_hclk) * COL_HT) + w_yo);

    // Row-stage error: malformed offset first, then out-of-device row
    always_comb begin
        if (!w_row_ok) begin
            w_row_code = ERR_OFFSET;
        end else if (w_y >= MAX_Y) begin
            w_row_code = ERR_RANGE;
        end else begin
            w_row_code = ERR_OK;
        end
    end

    // Capture the request, then step each stage's result into its register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fa    <= 32'd0;
            r_wo    <= 8'd0;
            r_lh    <= 1'b0;
            r_ml    <= 1'b0;
            r_ro    <= 1'b0;
            r_top   <= 1'b0;
            r_hclk  <= 5'd0;
            r_major <= 10'd0;
            r_minor <= 7'd0;
            r_x     <= 15'd0;
            r_y     <= 15'd0;
            r_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_fa  <= bus.Frame_address;
                        r_wo  <= bus.word_offset;
                        r_lh  <= bus.Lut_hi;
                        r_ml  <= bus.msb_lsb;
                        r_ro  <= bus.Row_odd;
                        r_err <= ERR_OK;
                    end
                end
                ST_LATCH: begin
                    r_top   <= r_fa[FA_TOP];
                    r_hclk  <= r_fa[FA_HCLK_MSB:FA_HCLK_LSB];
                    r_major <= r_fa[FA_MAJOR_MSB:FA_MAJOR_LSB];
                    r_minor <= r_fa[FA_MINOR_MSB:FA_MINOR_LSB];
                    r_err   <= merge_err(r_err, w_latch_code);
                end
                ST_COLUMN: begin
                    r_x   <= {w_x_hi, w_x0};
                    r_err <= merge_err(r_err, w_col_code);
                end
                ST_ROW: begin
                    r_y   <= w_y;
                    r_err <= merge_err(r_err, w_row_code);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs: results publish as DONE retires, held until next Start
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_xybel    <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_OK;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_error    <= 1'b0;
                r_err_code <= ERR_OK;
            end else if (r_state == ST_DONE) begin
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
                r_error    <= (r_err != ERR_OK);
                r_err_code <= r_err;
                r_xybel    <= (r_err == ERR_OK) ? {r_x, r_y, r_lh, r_ml} : 32'd0;
            end
        end
    end

    assign bus.XYBel    = r_xybel;
    assign bus.busy     = r_busy;
    assign bus.done_XY  = r_done;
    assign bus.error    = r_error;
    assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_lut_frame_decoder.sv
// Bench for lut_frame_decoder: directed vector table, multi-cycle corner
// sequences, and randomized requests against a rule-level reference model.
module tb_lut_frame_decoder;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   failures;

    lut_frame_decoder_if bus ();

    lut_frame_decoder dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] fa;
        logic [7:0]  wo;
        logic        lh;
        logic        ml;
        logic        ro;
        logic [31:0] exp_xy;
        int          exp_code;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_fa(input int blk, input int top, input int hclk,
                                          input int major, input int minor);
        logic [31:0] f;
        f = {6'd0, 3'(blk), 1'(top), 5'(hclk), 10'(major), 7'(minor)};
        return f;
    endfunction

    // Reference model built directly from the decode rules
    function automatic void model(input logic [31:0] fa, input int wo, input int lh,
                                  input int ml, input int r,
                                  output logic [31:0] xy, output int code);
        int top, hclk, major, minor, k, x, yo, y;
        bit c1, c2, c3, c4;
        top   = int'(fa[22]);
        hclk  = int'(fa[21:17]);
        major = int'(fa[16:7]);
        minor = int'(fa[6:0]);
        c4 = (fa[31:23] != 9'd0) || (top == 0 && hclk > 1);
        c1 = !(minor == 32 || minor == 26);
        k = -1;
        if      (major >= 2  && major <= 5)  k = 2;
        else if (major >= 7  && major <= 16) k = 3;
        else if (major >= 18 && major <= 19) k = 4;
        else if (major >= 21 && major <= 28) k = 5;
        else if (major >= 30 && major <= 41) k = 6;
        else if (major >= 43 && major <= 52) k = 7;
        else if (major >= 54 && major <= 57) k = 8;
        else if (major >= 59 && major <= 62) k = 9;
        c2 = (k < 0);
        x = 2 * (major - k) + ((minor == 26) ? 1 : 0);
        yo = -1;
        if (lh == 0 && wo >= 1  && wo <= 13 && !(wo == 13 && r == 1)) yo = 2 * (wo - 1) + r;
        if (lh == 0 && wo >= 14 && wo <= 26 && !(wo == 14 && r == 0)) yo = 2 * (wo - 2) + r;
        if (lh == 1 && wo >= 2  && wo <= 14 && !(wo == 14 && r == 1)) yo = 2 * (wo - 2) + r;
        if (lh == 1 && wo >= 15 && wo <= 27 && !(wo == 15 && r == 0)) yo = 2 * (wo - 3) + r;
        c3 = (yo < 0);
        y = (top == 1) ? yo : 50 + hclk * 50 + yo;
        if (!c3 && y >= 150) c4 = 1'b1;
        code = c1 ? 1 : c2 ? 2 : c3 ? 3 : c4 ? 4 : 0;
        if (code != 0) xy = 32'd0;
        else xy = 32'((x << 17) | (y << 2) | (lh << 1) | ml);
    endfunction

    // Issue one request and wait (bounded) for done_XY
    task automatic run_txn(input logic [31:0] fa, input logic [7:0] wo, input logic lh,
                           input logic ml, input logic ro,
                           output int lat, output logic busy_seen, output logic err_clr);
        @(negedge Clk);
        bus.Frame_address = fa;
        bus.word_offset   = wo;
        bus.Lut_hi        = lh;
        bus.msb_lsb       = ml;
        bus.Row_odd       = ro;
        bus.Start         = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        busy_seen = bus.busy;
        err_clr   = (bus.error == 1'b0) && (bus.err_code == 3'd0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk);
            #1;
            if (bus.done_XY) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic txn_and_check(input string tag, input logic [31:0] fa, input logic [7:0] wo,
                                 input logic lh, input logic ml, input logic ro,
                                 input logic [31:0] exp_xy, input int exp_code, input bit full);
        int   lat;
        logic bsy, clr;
        run_txn(fa, wo, lh, ml, ro, lat, bsy, clr);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " XYBel"}, bus.XYBel, exp_xy);
        check({tag, " err_code"}, 32'(bus.err_code), 32'(exp_code));
        check({tag, " error"}, 32'(bus.error), 32'(exp_code != 0));
        if (full) begin
            check({tag, " busy_after_start"}, 32'(bsy), 32'd1);
            check({tag, " err_cleared_on_start"}, 32'(clr), 32'd1);
            check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
            @(posedge Clk);
            #1;
            check({tag, " done_single_pulse"}, 32'(bus.done_XY), 32'd0);
            check({tag, " XYBel_held"}, bus.XYBel, exp_xy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] fa, exp_xy;
        int          exp_code, pulses, first, second, lat;
        logic        bsy, clr;

        checks   = 0;
        failures = 0;
        bus.Start = 1'b0; bus.Frame_address = 32'd0; bus.word_offset = 8'd0;
        bus.Lut_hi = 1'b0; bus.msb_lsb = 1'b0; bus.Row_odd = 1'b0;

        vecs[0]  = '{mk_fa(0,0,0,2,32),  8'd1,  1'b0, 1'b0, 1'b0, 32'h000000C8, 0};
        vecs[1]  = '{mk_fa(0,1,0,19,26), 8'd15, 1'b1, 1'b1, 1'b1, 32'h003E0067, 0};
        vecs[2]  = '{mk_fa(0,0,1,62,26), 8'd26, 1'b0, 1'b0, 1'b1, 32'h00D60254, 0};
        vecs[3]  = '{mk_fa(0,0,0,6,32),  8'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 2};
        vecs[4]  = '{mk_fa(0,0,0,6,5),   8'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 1};
        vecs[5]  = '{mk_fa(0,0,0,2,32),  8'd13, 1'b0, 1'b0, 1'b1, 32'h00000000, 3};
        vecs[6]  = '{mk_fa(0,0,2,2,32),  8'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 4};
        vecs[7]  = '{mk_fa(1,0,0,2,32),  8'd1,  1'b0, 1'b0, 1'b0, 32'h00000000, 4};
        vecs[8]  = '{mk_fa(0,1,0,5,32),  8'd13, 1'b0, 1'b0, 1'b0, 32'h000C0060, 0};
        vecs[9]  = '{mk_fa(0,1,0,5,32),  8'd14, 1'b0, 1'b0, 1'b0, 32'h00000000, 3};
        vecs[10] = '{mk_fa(0,1,0,5,32),  8'd1,  1'b1, 1'b0, 1'b0, 32'h00000000, 3};
        vecs[11] = '{mk_fa(0,1,0,7,26),  8'd14, 1'b0, 1'b0, 1'b1, 32'h00120064, 0};
        vecs[12] = '{32'h80000000 | mk_fa(0,1,0,2,32), 8'd1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4};
        vecs[13] = '{mk_fa(0,0,1,2,32),  8'd27, 1'b1, 1'b0, 1'b1, 32'h00000256, 0};

        // Reset state
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset XYBel", bus.XYBel, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done_XY", 32'(bus.done_XY), 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        check("reset err_code", 32'(bus.err_code), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            txn_and_check($sformatf("vec%0d", i), vecs[i].fa, vecs[i].wo, vecs[i].lh,
                          vecs[i].ml, vecs[i].ro, vecs[i].exp_xy, vecs[i].exp_code, 1'b1);
        end

        // Start held high for 10 cycles: only two requests accepted, 5 cycles apart
        repeat (2) @(posedge Clk);
        bus.Frame_address = mk_fa(0,0,0,2,32);
        bus.word_offset = 8'd1; bus.Lut_hi = 1'b0; bus.msb_lsb = 1'b0; bus.Row_odd = 1'b0;
        pulses = 0; first = -1; second = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (bus.done_XY) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            bus.Start = (c < 10);
        end
        bus.Start = 1'b0;
        check("held_start pulse_count", 32'(pulses), 32'd2);
        check("held_start pulse_gap", 32'(second - first), 32'd5);

        // Reset during ROW aborts the request
        txn_and_check("pre_reset", vecs[1].fa, vecs[1].wo, vecs[1].lh, vecs[1].ml,
                      vecs[1].ro, vecs[1].exp_xy, 0, 1'b0);
        @(negedge Clk);
        bus.Frame_address = vecs[2].fa; bus.word_offset = vecs[2].wo;
        bus.Lut_hi = vecs[2].lh; bus.msb_lsb = vecs[2].ml; bus.Row_odd = vecs[2].ro;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midreset XYBel", bus.XYBel, 32'd0);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done_XY", 32'(bus.done_XY), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (bus.done_XY) pulses++;
        end
        check("midreset no_done", 32'(pulses), 32'd0);
        txn_and_check("post_reset", vecs[2].fa, vecs[2].wo, vecs[2].lh, vecs[2].ml,
                      vecs[2].ro, vecs[2].exp_xy, vecs[2].exp_code, 1'b1);

        // Randomized requests against the reference model
        for (int n = 0; n < 300; n++) begin
            int sel, blk, minor;
            logic [7:0] wo;
            logic lh, ml, ro;
            sel   = int'($urandom_range(0, 7));
            minor = (sel < 3) ? 32 : (sel < 6) ? 26 : int'($urandom_range(0, 127));
            blk   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
            fa    = mk_fa(blk, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 63)), minor);
            if ($urandom_range(0, 19) == 0) fa[31:26] = 6'($urandom_range(1, 63));
            wo = 8'($urandom_range(0, 28));
            lh = 1'($urandom_range(0, 1));
            ml = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            model(fa, int'(wo), int'(lh), int'(ml), int'(ro), exp_xy, exp_code);
            run_txn(fa, wo, lh, ml, ro, lat, bsy, clr);
            check($sformatf("rand%0d latency", n), 32'(lat), 32'd4);
            check($sformatf("rand%0d XYBel fa=%08h wo=%0d", n, fa, wo), bus.XYBel, exp_xy);
            check($sformatf("rand%0d err_code", n), 32'(bus.err_code), 32'(exp_code));
            check($sformatf("rand%0d error", n), 32'(bus.error), 32'(exp_code != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
